// File: rtl/data_ram_ws.sv
// Word-organised single-port data RAM with programmable wait states, byte
// write enables and an out-of-range error pulse; stalls the core while busy.
module data_ram_ws #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    ram_stall,
  output logic                    err
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam bit          HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             access_c;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign in_range_c = ({1'b0, addr} < DEPTH_L);
  assign idx_c      = IDX_W'(addr);

  // Stall covers the request cycle and every BUSY cycle; never during reset.
  assign ram_stall = HAS_WAIT & rst & cs & ((state_q == IDLE) | (state_q == BUSY));

  // Next-state logic; access_c marks the edge on which an access completes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    access_c = 1'b0;
    if (!HAS_WAIT) begin
      state_d  = IDLE;
      cnt_d    = '0;
      access_c = cs & rst;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        BUSY: begin
          if (!cs) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d  = DONE;
            access_c = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout    <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err     <= access_c & ~in_range_c;
      if (access_c && !we) begin
        dout <= in_range_c ? mem[idx_c] : '0;
      end
    end
  end

  // Array has no reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (access_c && we && in_range_c) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[idx_c][i*8 +: 8] <= din[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_ws.sv
// Directed bench for data_ram_ws: a 2-wait-state instance and a zero-wait instance.
module tb_data_ram_ws;

  logic clk;
  logic rst;

  logic        cs2, we2, stall2, err2;
  logic [3:0]  be2;
  logic [10:0] addr2;
  logic [31:0] din2, dout2;

  logic        cs0, we0, stall0, err0;
  logic [3:0]  be0;
  logic [10:0] addr0;
  logic [31:0] din0, dout0;

  int total = 0;
  int bad   = 0;

  data_ram_ws #(.ADDR_WIDTH(11), .DEPTH(1024), .DATA_WIDTH(32), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .cs(cs2), .we(we2), .be(be2), .addr(addr2), .din(din2),
    .dout(dout2), .ram_stall(stall2), .err(err2)
  );

  data_ram_ws #(.ADDR_WIDTH(11), .DEPTH(1024), .DATA_WIDTH(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .cs(cs0), .we(we0), .be(be0), .addr(addr0), .din(din0),
    .dout(dout0), .ram_stall(stall0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one access on the wait-state instance; called at posedge+1, returns at posedge+1.
  task automatic acc2(input logic w, input logic [3:0] b, input logic [10:0] a,
                      input logic [31:0] d, output int stalls, output int errs,
                      output logic [31:0] rd, output logic done_err);
    cs2 = 1'b1; we2 = w; be2 = b; addr2 = a; din2 = d;
    stalls = 0; errs = 0; rd = 'x; done_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (stall2) begin
        stalls++;
        if (err2) errs++;
        @(posedge clk); #1;
      end else begin
        rd = dout2;
        done_err = err2;
        if (err2) errs++;
        break;
      end
    end
    @(posedge clk); #1;
    cs2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cs2 = 1'b1; we2 = 1'b0; be2 = 4'h0; addr2 = '0; din2 = '0;
    cs0 = 1'b0; we0 = 1'b0; be0 = 4'h0; addr0 = '0; din0 = '0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    total++; if (stall2 !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall2); end
    total++; if (dout2 !== 32'h0) begin bad++; $display("FAIL reset_dout2 got=%h want=0", dout2); end
    total++; if (err2 !== 1'b0) begin bad++; $display("FAIL reset_err2 got=%b want=0", err2); end
    total++; if (dout0 !== 32'h0) begin bad++; $display("FAIL reset_dout0 got=%h want=0", dout0); end
    cs2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int s, e; logic [31:0] rd; logic de;
    acc2(1'b1, 4'hF, 11'd5, 32'hDEADBEEF, s, e, rd, de);
    total++; if (s != 3) begin bad++; $display("FAIL wr_stall_cycles got=%0d want=3", s); end
    total++; if (e != 0) begin bad++; $display("FAIL wr_err got=%0d want=0", e); end
    acc2(1'b0, 4'h0, 11'd5, 32'h0, s, e, rd, de);
    total++; if (s != 3) begin bad++; $display("FAIL rd_stall_cycles got=%0d want=3", s); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", rd); end
    total++; if (e != 0) begin bad++; $display("FAIL rd_err got=%0d want=0", e); end
    #1;
    total++; if (dout2 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got=%h want=deadbeef", dout2); end
  endtask

  task automatic test_byte_en();
    int s, e; logic [31:0] rd; logic de;
    acc2(1'b1, 4'b0101, 11'd5, 32'h11223344, s, e, rd, de);
    acc2(1'b0, 4'h0, 11'd5, 32'h0, s, e, rd, de);
    total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL be_merge got=%h want=de22be44", rd); end
    acc2(1'b1, 4'b0000, 11'd5, 32'hFFFFFFFF, s, e, rd, de);
    total++; if (s != 3 || e != 0) begin bad++; $display("FAIL be_zero_timing got=%0d/%0d want=3/0", s, e); end
    acc2(1'b0, 4'hF, 11'd5, 32'h0, s, e, rd, de);
    total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL be_zero_data got=%h want=de22be44", rd); end
  endtask

  task automatic test_out_of_range();
    int s, e; logic [31:0] rd; logic de;
    acc2(1'b1, 4'hF, 11'd0, 32'h0BADF00D, s, e, rd, de);
    acc2(1'b1, 4'hF, 11'd1024, 32'hFFFFFFFF, s, e, rd, de);
    total++; if (s != 3) begin bad++; $display("FAIL oor_wr_stall got=%0d want=3", s); end
    total++; if (e != 1 || de !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%0d/%b want=1/1", e, de); end
    #1;
    total++; if (err2 !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got=%b want=0", err2); end
    acc2(1'b0, 4'h0, 11'd1024, 32'h0, s, e, rd, de);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd_data got=%h want=0", rd); end
    total++; if (e != 1 || de !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%0d/%b want=1/1", e, de); end
    acc2(1'b0, 4'h0, 11'd0, 32'h0, s, e, rd, de);
    total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL oor_addr0 got=%h want=0badf00d", rd); end
    total++; if (e != 0) begin bad++; $display("FAIL oor_addr0_err got=%0d want=0", e); end
  endtask

  task automatic test_abort();
    int s, e; logic [31:0] rd; logic de;
    int errs_seen;
    acc2(1'b1, 4'hF, 11'd9, 32'h55AA0001, s, e, rd, de);
    acc2(1'b0, 4'h0, 11'd0, 32'h0, s, e, rd, de);
    errs_seen = 0;
    cs2 = 1'b1; we2 = 1'b1; be2 = 4'hF; addr2 = 11'd9; din2 = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cs2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; if (err2) errs_seen++;
      @(posedge clk); #1;
    end
    total++; if (errs_seen != 0) begin bad++; $display("FAIL abort_err got=%0d want=0", errs_seen); end
    total++; if (dout2 !== 32'h0BADF00D) begin bad++; $display("FAIL abort_dout got=%h want=0badf00d", dout2); end
    acc2(1'b0, 4'h0, 11'd9, 32'h0, s, e, rd, de);
    total++; if (s != 3) begin bad++; $display("FAIL abort_idle got=%0d want=3", s); end
    total++; if (rd !== 32'h55AA0001) begin bad++; $display("FAIL abort_data got=%h want=55aa0001", rd); end
  endtask

  task automatic test_wait0();
    cs0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 11'd7; din0 = 32'hA5A5A5A5;
    #1;
    total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL w0_wr_stall got=%b want=0", stall0); end
    @(posedge clk); #1;
    we0 = 1'b0;
    #1;
    total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL w0_rd_stall got=%b want=0", stall0); end
    total++; if (dout0 !== 32'h0) begin bad++; $display("FAIL w0_dout_early got=%h want=0", dout0); end
    @(posedge clk); #1;
    addr0 = 11'd2000;
    #1;
    total++; if (dout0 !== 32'hA5A5A5A5) begin bad++; $display("FAIL w0_rd_data got=%h want=a5a5a5a5", dout0); end
    total++; if (err0 !== 1'b0) begin bad++; $display("FAIL w0_rd_err got=%b want=0", err0); end
    @(posedge clk); #1;
    cs0 = 1'b0;
    #1;
    total++; if (err0 !== 1'b1) begin bad++; $display("FAIL w0_oor_err got=%b want=1", err0); end
    total++; if (dout0 !== 32'h0) begin bad++; $display("FAIL w0_oor_dout got=%h want=0", dout0); end
    @(posedge clk); #2;
    total++; if (err0 !== 1'b0) begin bad++; $display("FAIL w0_err_clear got=%b want=0", err0); end
  endtask

  task automatic test_async_reset();
    int s, e; logic [31:0] rd; logic de;
    acc2(1'b0, 4'h0, 11'd5, 32'h0, s, e, rd, de);
    cs2 = 1'b1; we2 = 1'b1; be2 = 4'hF; addr2 = 11'd5; din2 = 32'h00000000;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    total++; if (stall2 !== 1'b0) begin bad++; $display("FAIL arst_stall got=%b want=0", stall2); end
    total++; if (err2 !== 1'b0) begin bad++; $display("FAIL arst_err got=%b want=0", err2); end
    total++; if (dout2 !== 32'h0) begin bad++; $display("FAIL arst_dout got=%h want=0", dout2); end
    @(posedge clk); #1;
    cs2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    acc2(1'b0, 4'h0, 11'd5, 32'h0, s, e, rd, de);
    total++; if (s != 3) begin bad++; $display("FAIL arst_rd_stall got=%0d want=3", s); end
    total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL arst_rd_data got=%h want=de22be44", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_en();
    test_out_of_range();
    test_abort();
    test_wait0();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
